// File: rtl/mp_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters.
// A tag pipeline tracks the owner of each in-flight product so results carry their requester id.
module mp_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [NREQ-1:0]    req_valid_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic [NREQ*24-1:0] req_mpcand_i,
    input  logic [NREQ*16-1:0] req_mplier_i,
    output logic [23:0]        mpcand_o,
    output logic [15:0]        mplier_o,
    input  logic [23:0]        mprod_i,
    output logic               res_valid_o,
    output logic [IDW-1:0]     res_id_o,
    output logic [23:0]        res_data_o,
    output logic               busy_o
);

    logic [23:0]     mpcand_q, mpcand_d;
    logic [15:0]     mplier_q, mplier_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [LATENCY:0] tag_valid_q;
    logic [IDW-1:0]  tag_id_q [LATENCY+1];

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic [IDW-1:0]  idx;

    // Search starts just after the last granted requester.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        if (en_i) begin
            for (int i = 1; i <= int'(NREQ); i++) begin
                idx = IDW'((int'(ptr_q) + i) % int'(NREQ));
                if (!grant_any && req_valid_i[idx]) begin
                    grant_any   = 1'b1;
                    grant_id    = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mpcand_d = '0;
        mplier_d = '0;
        ptr_d    = ptr_q;
        if (grant_any) begin
            mpcand_d = req_mpcand_i[24*int'(grant_id) +: 24];
            mplier_d = req_mplier_i[16*int'(grant_id) +: 16];
            ptr_d    = grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpcand_q    <= '0;
            mplier_q    <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            tag_valid_q <= '0;
            for (int i = 0; i <= int'(LATENCY); i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            mpcand_q    <= mpcand_d;
            mplier_q    <= mplier_d;
            ptr_q       <= ptr_d;
            // Shifts unconditionally: the multiplier never stalls.
            tag_valid_q <= {tag_valid_q[LATENCY-1:0], grant_any};
            tag_id_q[0] <= grant_id;
            for (int i = 1; i <= int'(LATENCY); i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign req_ready_o = grant;
    assign mpcand_o    = mpcand_q;
    assign mplier_o    = mplier_q;
    assign res_valid_o = tag_valid_q[LATENCY];
    assign res_id_o    = tag_valid_q[LATENCY] ? tag_id_q[LATENCY] : '0;
    assign res_data_o  = mprod_i;
    assign busy_o      = |tag_valid_q;

endmodule

// File: tb/tb_mp_sched.sv
// Bench for mp_sched: directed and random requests against a queue-based reference model,
// with a simple non-resetting pipelined multiplier model feeding mprod_i.
module tb_mp_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int IDW  = 2;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*24-1:0] req_mpcand;
    logic [NREQ*16-1:0] req_mplier;
    logic [23:0]        mpcand;
    logic [15:0]        mplier;
    logic [23:0]        mprod;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [23:0]        res_data;
    logic               busy;

    mp_sched #(.NREQ(NREQ), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_mpcand_i (req_mpcand),
        .req_mplier_i (req_mplier),
        .mpcand_o     (mpcand),
        .mplier_o     (mplier),
        .mprod_i      (mprod),
        .res_valid_o  (res_valid),
        .res_id_o     (res_id),
        .res_data_o   (res_data),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mul(logic [23:0] a, logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 15;
        return p[23:0];
    endfunction

    // Multiplier core: captures the operand registers, product after LAT edges from issue.
    logic [23:0] mpipe [LAT];
    always_ff @(posedge clk) begin
        mpipe[0] <= mul(mpcand, mplier);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mprod = mpipe[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [23:0] data;
    } exp_t;

    exp_t        q[$];
    int          m_ptr;
    logic [23:0] m_cand;
    logic [15:0] m_plier;
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NREQ; k++) begin
            req_mpcand[24*k +: 24] = 24'($urandom);
            req_mplier[16*k +: 16] = 16'($urandom);
        end
    endtask

    // One clock: check outputs against the model, take the edge, advance the model.
    task automatic tick();
        logic [NREQ-1:0] exp_rdy;
        logic            hs_v;
        int              hs_k;
        int              k;
        #1;
        if (!rst_n) begin
            q.delete();
            m_ptr   = NREQ - 1;
            m_cand  = '0;
            m_plier = '0;
        end
        exp_rdy = '0;
        hs_v    = 1'b0;
        hs_k    = 0;
        if (en) begin
            for (int i = 1; i <= NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (!hs_v && req_valid[k]) begin
                    hs_v       = 1'b1;
                    hs_k       = k;
                    exp_rdy[k] = 1'b1;
                end
            end
        end
        chk("ready", 32'(req_ready), 32'(exp_rdy));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_id", 32'(res_id), 32'(q[0].id));
            chk("res_data", 32'(res_data), 32'(q[0].data));
        end else begin
            chk("res_valid", 32'(res_valid), 32'd0);
            chk("res_id", 32'(res_id), 32'd0);
        end
        chk("mpcand", 32'(mpcand), 32'(m_cand));
        chk("mplier", 32'(mplier), 32'(m_plier));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        @(posedge clk);
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (hs_v) begin
                m_cand  = req_mpcand[24*hs_k +: 24];
                m_plier = req_mplier[16*hs_k +: 16];
                m_ptr   = hs_k;
                q.push_back('{cyc + 1 + LAT, hs_k, mul(m_cand, m_plier)});
            end else begin
                m_cand  = '0;
                m_plier = '0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle(int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        m_ptr      = NREQ - 1;
        m_cand     = '0;
        m_plier    = '0;
        rst_n      = 1'b0;
        en         = 1'b0;
        req_valid  = '1;
        req_mpcand = '0;
        req_mplier = '0;
        rand_ops();
        @(negedge clk);

        // Reset held with all valids high and en low, then 8 cycles without grants.
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Single op from requester 0.
        en = 1'b1;
        req_valid = 4'b0001;
        req_mpcand[23:0] = 24'h100000;
        req_mplier[15:0] = 16'h4000;
        tick();
        idle(LAT + 2);

        // All four valid from reset: rotation 0,1,2,3,0,1,2,3 with back-to-back results.
        do_reset();
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            tick();
        end
        idle(LAT + 2);

        // Negative operands.
        req_mpcand[24*2 +: 24] = 24'hFFFF00;
        req_mplier[16*2 +: 16] = 16'h7FFF;
        req_mpcand[24*3 +: 24] = 24'h000010;
        req_mplier[16*3 +: 16] = 16'h8000;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1000;
        tick();
        idle(LAT + 2);

        // Enable dropped after two grants, then re-raised.
        req_valid = '1;
        rand_ops();
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            tick();
        end
        idle(LAT + 2);

        // Single-cycle reset with three ops in flight.
        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            tick();
        end
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        idle(LAT + 3);

        // Random traffic with occasional resets and enable drops.
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom);
            en = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            rand_ops();
            tick();
        end
        rst_n = 1'b1;
        idle(LAT + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
